spike_aer_encoder: RTL and testbench
====================================

// Module: spike_aer_encoder
// PURPOSE
//   Downstream of the superneuron array. Converts per-neuron spike levels into
//   address-event (AER) packets: neuron index plus optional timestamp. Packets are
//   queued in a FIFO and drained over a valid/ready stream toward the router/host.
// PARAMETERS
//   N_NEURONS   8    number of spike inputs, one per neuron (>=2)
//   ADDR_W      3    event address width; 2**ADDR_W >= N_NEURONS
//   FIFO_DEPTH  8    event FIFO entries; power of two, >=2
//   TS_W        16   timestamp width; used only with SPIKE_AER_TIMESTAMP_EN
// PORTS
//   clk         in   1               clock; all state updates on the rising edge
//   reset       in   1               asynchronous, active-high
//   spike_in    in   N_NEURONS       spike levels from the neurons; may stay high many cycles
//   aer_valid   out  1               head FIFO entry is valid
//   aer_ready   in   1               consumer accepts the head entry
//   aer_addr    out  ADDR_W          neuron index of the head entry
//   aer_ts      out  TS_W            timestamp of the head entry (0 when the feature is out)
//   fifo_level  out  clog2(DEPTH)+1  entries currently stored
//   drop_count  out  16              saturating count of coalesced/lost events
// BEHAVIOUR
//   - Reset: aer_valid=0, aer_addr=0, aer_ts=0, fifo_level=0, drop_count=0.
//     Also clears spike_d, pending, FIFO pointers and ts_cnt. last_grant=N_NEURONS-1.
//     Reset asserted mid-operation flushes all queued and pending events immediately.
//   - Edge detect: spike_d <= spike_in every cycle; edge = spike_in & ~spike_d.
//     Only rising edges generate events. A level held high yields exactly one event.
//     A level high at reset release yields one event.
//   - Pending: pending[i] <= (pending[i] & ~grant[i]) | edge[i].
//     If edge[i] occurs while pending[i] is set and not granted that cycle, the new
//     edge is merged into the existing pending bit and drop_count increments.
//     drop_count saturates at 16'hFFFF.
//     An edge in the same cycle as grant[i] re-sets pending[i]; this is not a drop.
//   - Arbiter: round-robin over pending, searching from last_grant+1 and wrapping at
//     N_NEURONS-1 -> 0.
//     Grants at most one event per cycle, only when fifo_level < FIFO_DEPTH.
//     Full is evaluated on the registered level; a same-cycle pop does not enable a
//     push. On a grant, last_grant <= granted index.
//   - FIFO push: granted {index, ts_cnt} is written at that clock edge.
//   - Latency: spike_in rises before edge k -> pending set at edge k -> pushed at
//     edge k+1. aer_valid is high after edge k+1 when the FIFO was empty and nothing
//     else is pending.
//   - Stream: show-ahead FIFO; aer_valid = (fifo_level != 0).
//     Pop when aer_valid & aer_ready. Simultaneous push and pop leaves the level
//     unchanged. aer_addr/aer_ts are stable while aer_valid=1 and aer_ready=0.
//     Order out equals grant order.
//   - ts_cnt: free-running TS_W counter, +1 every cycle, wraps 2**TS_W-1 -> 0.
// CONFIGURATION
//   SPIKE_AER_TIMESTAMP_EN
//     Defined: ts_cnt is implemented. FIFO entry = ADDR_W+TS_W bits.
//       aer_ts = ts_cnt value at the grant edge.
//     Undefined: no counter. FIFO entry = ADDR_W bits. aer_ts tied to 0.
//       All other behaviour is identical.
// TESTING
//   1 Single spike: spike_in[3] high 5 cycles, aer_ready=1.
//     -> exactly one event addr=3; aer_valid high 1 cycle, 2 cycles after the rise.
//   2 Burst: spike_in 8'h00->8'hFF in one cycle, aer_ready=1.
//     -> addrs 0..7 on 8 consecutive cycles; drop_count=0.
//   3 Backpressure: aer_ready=0, burst 8'hFF -> fifo_level=8.
//     Toggle spike_in[2] low/high twice -> drop_count=1.
//     Then aer_ready=1 -> 9 events: 0..7, then 2.
//   4 Round-robin: last_grant=5, pending bits 0 and 5 set -> grant 0 first, then 5.
//     Same-cycle edge on a granted bit -> re-pended, no drop.
//   5 SPIKE_AER_TIMESTAMP_EN: ts_cnt=16'hFFFE at grant -> aer_ts=16'hFFFE.
//     A grant two cycles later -> aer_ts=16'h0000 (wrap).
//   6 Reset mid-stream: fifo_level=5, pending!=0, assert reset.
//     -> aer_valid=0, fifo_level=0, drop_count=0 immediately (asynchronous).

Source files
------------

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: spike rising edges -> round-robin arbiter -> show-ahead FIFO -> AER valid/ready stream.
// Define SPIKE_AER_TIMESTAMP_EN to attach a free-running timestamp to every event.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_NEURONS-1:0]          spike_in,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic [TS_W-1:0]               aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
`ifdef SPIKE_AER_TIMESTAMP_EN
  localparam int EW = ADDR_W + TS_W;
`else
  localparam int EW = ADDR_W;
`endif

  logic [N_NEURONS-1:0] spike_d, pending, rise, grant, drops;
  logic [ADDR_W-1:0]    last_grant, grant_idx, hi_idx, lo_idx;
  logic                 grant_en, hi_en, lo_en, pop;
  logic [16:0]          drop_sum;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        wr_data, head;
  logic [PW-1:0]        wr_ptr, rd_ptr;

  assign rise  = spike_in & ~spike_d;
  assign drops = rise & pending & ~grant;

  // Prefer the lowest pending index above last_grant, else wrap to the lowest overall.
  always_comb begin
    hi_en  = 1'b0;
    lo_en  = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_en  = 1'b1;
        lo_idx = ADDR_W'(i);
      end
      if (pending[i] && ADDR_W'(i) > last_grant) begin
        hi_en  = 1'b1;
        hi_idx = ADDR_W'(i);
      end
    end
    grant_en  = (hi_en | lo_en) & (fifo_level != FULL);
    grant_idx = hi_en ? hi_idx : lo_idx;
    grant     = grant_en ? {{(N_NEURONS-1){1'b0}}, 1'b1} << grant_idx : '0;
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < N_NEURONS; i++) drop_sum = drop_sum + 17'(drops[i]);
  end

  assign aer_valid = fifo_level != '0;
  assign pop       = aer_valid & aer_ready;
  assign head      = mem[rd_ptr];

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + 1'b1;
  assign wr_data  = {grant_idx, ts_cnt};
  assign aer_addr = aer_valid ? head[EW-1:TS_W] : '0;
  assign aer_ts   = aer_valid ? head[TS_W-1:0] : '0;
`else
  assign wr_data  = grant_idx;
  assign aer_addr = aer_valid ? head : '0;
  assign aer_ts   = '0;
`endif

  always_ff @(posedge clk) if (grant_en) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_d    <= '0;
      pending    <= '0;
      last_grant <= ADDR_W'(N_NEURONS - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      spike_d    <= spike_in;
      pending    <= (pending & ~grant) | rise;
      last_grant <= grant_en ? grant_idx : last_grant;
      wr_ptr     <= wr_ptr + PW'(grant_en);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_level <= fifo_level + (PW + 1)'(grant_en) - (PW + 1)'(pop);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: directed checks of edge detection, arbitration, FIFO, drops and reset.
module tb_spike_aer_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  spike_in;
  logic        aer_valid, aer_ready;
  logic [2:0]  aer_addr;
  logic [15:0] aer_ts;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  int          n_run = 0, n_fail = 0;
  logic [2:0]  q[$];

  spike_aer_encoder dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .aer_valid(aer_valid),
    .aer_ready(aer_ready), .aer_addr(aer_addr), .aer_ts(aer_ts),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && aer_valid && aer_ready) q.push_back(aer_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_rst();
    reset = 1'b1;
    q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_q(input string tag, input logic [2:0] exp[$]);
    chk({tag, "_size"}, 32'(q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < q.size(); i++) chk(tag, 32'(q[i]), 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b1;
    spike_in = '0;
    aer_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(aer_valid), 0);
    chk("rst_addr", 32'(aer_addr), 0);
    chk("rst_ts", 32'(aer_ts), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop", 32'(drop_count), 0);
    reset = 1'b0;

    // single spike held 5 cycles
    spike_in = 8'h08;
    aer_ready = 1'b1;
    tick();
    chk("t1_valid_e1", 32'(aer_valid), 0);
    tick();
    chk("t1_valid_e2", 32'(aer_valid), 1);
    chk("t1_addr", 32'(aer_addr), 3);
    chk("t1_level", 32'(fifo_level), 1);
`ifdef SPIKE_AER_TIMESTAMP_EN
    chk("t1_ts", 32'(aer_ts), 1);
`else
    chk("t1_ts", 32'(aer_ts), 0);
`endif
    tick();
    chk("t1_valid_e3", 32'(aer_valid), 0);
    tick();
    tick();
    spike_in = '0;
    tick();
    tick();
    chk("t1_valid_end", 32'(aer_valid), 0);
    chk_q("t1_q", '{3'd3});

    // burst 00->FF, consecutive drain
    do_rst();
    spike_in = 8'hFF;
    aer_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_valid", 32'(aer_valid), 1);
      chk("t2_addr", 32'(aer_addr), 32'(i));
    end
    tick();
    chk("t2_valid_end", 32'(aer_valid), 0);
    chk("t2_drop", 32'(drop_count), 0);

    // backpressure, fill, one coalesced edge
    do_rst();
    aer_ready = 1'b0;
    spike_in = 8'hFF;
    repeat (9) tick();
    chk("t3_level_full", 32'(fifo_level), 8);
    chk("t3_head", 32'(aer_addr), 0);
    spike_in = 8'hFB;
    tick();
    spike_in = 8'hFF;
    tick();
    chk("t3_drop0", 32'(drop_count), 0);
    spike_in = 8'hFB;
    tick();
    spike_in = 8'hFF;
    tick();
    chk("t3_drop1", 32'(drop_count), 1);
    chk("t3_level_hold", 32'(fifo_level), 8);
    aer_ready = 1'b1;
    repeat (14) tick();
    chk_q("t3_q", '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2});
    chk("t3_drop_end", 32'(drop_count), 1);

    // mid-stream async reset, then levels high at release
    spike_in = '0;
    aer_ready = 1'b0;
    tick();
    spike_in = 8'h1F;
    repeat (5) tick();
    spike_in = 8'h3F;
    tick();
    chk("t6_level", 32'(fifo_level), 5);
    #1 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(aer_valid), 0);
    chk("t6_level0", 32'(fifo_level), 0);
    chk("t6_drop0", 32'(drop_count), 0);
    q.delete();
    tick();
    reset = 1'b0;
    aer_ready = 1'b1;
    repeat (10) tick();
    chk_q("t6_q", '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});

    // round-robin wrap and same-cycle re-pend
    spike_in = '0;
    do_rst();
    aer_ready = 1'b1;
    spike_in = 8'h20;
    tick();
    tick();
    spike_in = '0;
    tick();
    tick();
    spike_in = 8'h21;
    tick();
    spike_in = 8'h01;
    tick();
    spike_in = 8'h21;
    tick();
    tick();
    spike_in = '0;
    repeat (4) tick();
    chk_q("t4_q", '{3'd5, 3'd0, 3'd5, 3'd5});
    chk("t4_drop", 32'(drop_count), 0);

`ifdef SPIKE_AER_TIMESTAMP_EN
    do_rst();
    aer_ready = 1'b0;
    repeat (65533) tick();
    spike_in = 8'h02;
    tick();
    tick();
    chk("t5_ts_fffe", 32'(aer_ts), 32'hFFFE);
    spike_in = 8'h12;
    tick();
    tick();
    chk("t5_level", 32'(fifo_level), 2);
    chk("t5_head_addr", 32'(aer_addr), 1);
    aer_ready = 1'b1;
    tick();
    chk("t5_addr2", 32'(aer_addr), 4);
    chk("t5_ts_wrap", 32'(aer_ts), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
